aes_round_ctrl: RTL

- Sequencing controller for the iterative AES-128 encryption datapath: the state-matrix register, AddRoundKey, SubBytes/ShiftRows/MixColumns and the on-the-fly key expander.
- Accepts one block per valid/ready handshake and issues the initial AddRoundKey load.
- Steps the datapath through NR rounds and suppresses MixColumns on the last round.
- Drives the round constant (rcon) to the key expander and presents completion to the consumer through a valid/ready output handshake.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_round_ctrl_if.sv | 18 +
 rtl/aes_rcon_gen.sv | 27 ++
 rtl/aes_round_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helper for the AES-128 round sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned RCON_W    = 8;
    localparam int unsigned CNT_W     = 16;

    localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;
    localparam logic [RCON_W-1:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] b);
        return {b[RCON_W-2:0], 1'b0} ^ (b[RCON_W-1] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-level valid/ready handshake plus flush between producer, controller and consumer.
interface aes_round_ctrl_if;
    logic in_valid;
    logic in_ready_c;
    logic abort;
    logic out_valid;
    logic out_ready;

    modport slave (
        input  in_valid, abort, out_ready,
        output in_ready_c, out_valid
    );

    modport master (
        output in_valid, abort, out_ready,
        input  in_ready_c, out_valid
    );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key expander: restarts on load, doubles in GF(2^8) on step.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    output logic [RCON_W-1:0] rcon_o
);

    logic [RCON_W-1:0] rcon_q, rcon_d;

    always_ff @(posedge clk) begin
        if (rst) rcon_q <= RCON_INIT;
        else     rcon_q <= rcon_d;
    end

    always_comb begin
        rcon_d = rcon_q;
        if (load_i)      rcon_d = RCON_INIT;
        else if (step_i) rcon_d = xtime(rcon_q);
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: load, NR timed round commits, then
// hold the cipher until the consumer takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR           = NR_AES128,
    parameter int unsigned ROUND_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    aes_round_ctrl_if.slave    bus,
    output logic               dp_load_c_o,
    output logic               dp_round_en_c_o,
    output logic               dp_final_c_o,
    output logic               key_step_c_o,
    output logic [ROUND_W-1:0] round_idx_o,
    output logic [RCON_W-1:0]  rcon_o,
    output logic               busy_c_o,
    output logic [CNT_W-1:0]   blk_count_o
);

    localparam int unsigned        CYC_W      = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(ROUND_CYCLES - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NR);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   blk_count_q, blk_count_d;
    logic               in_ready, accept, commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            blk_count_q <= blk_count_d;
        end
    end

    // Abort always wins over a commit or an output handshake in the same cycle.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        blk_count_d = blk_count_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = !bus.abort;
                accept   = in_ready && bus.in_valid;
                if (accept) begin
                    state_d = ST_ROUND;
                    round_d = ROUND_W'(1);
                    cyc_d   = '0;
                end
            end
            ST_ROUND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    cyc_d   = '0;
                end else if (cyc_q == CYC_LAST) begin
                    commit = 1'b1;
                    cyc_d  = '0;
                    if (round_q == ROUND_LAST) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    round_d     = '0;
                end else if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    round_d     = '0;
                    blk_count_d = blk_count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (commit),
        .rcon_o (rcon_o)
    );

    assign bus.in_ready_c    = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign dp_load_c_o       = accept;
    assign dp_round_en_c_o   = commit;
    assign key_step_c_o      = commit;
    assign dp_final_c_o      = (state_q == ST_ROUND) && (round_q == ROUND_LAST);
    assign busy_c_o          = (state_q != ST_IDLE);
    assign round_idx_o       = round_q;
    assign blk_count_o       = blk_count_q;

endmodule
